// File: rtl/opl2_host_bus_master.sv
// OPL2 host-bus initiator: sequences register writes (address then data phase, each followed by
// chip recovery) and status reads; one request at a time, req_ready low while a cycle is in flight.
module opl2_host_bus_master #(
    parameter int DATA_WIDTH       = 8,
    parameter int SETUP_CYCLES     = 1,
    parameter int STROBE_CYCLES    = 2,
    parameter int HOLD_CYCLES      = 1,
    parameter int ADDR_WAIT_CYCLES = 12,
    parameter int DATA_WAIT_CYCLES = 84
) (
    input  logic                  clk,
    input  logic                  ic_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rd,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  cs_n,
    output logic                  wr_n,
    output logic                  rd_n,
    output logic                  address,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic [DATA_WIDTH-1:0] bus_din
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] A_SETUP  = 4'd1;
    localparam logic [3:0] A_STROBE = 4'd2;
    localparam logic [3:0] A_HOLD   = 4'd3;
    localparam logic [3:0] A_WAIT   = 4'd4;
    localparam logic [3:0] D_SETUP  = 4'd5;
    localparam logic [3:0] D_STROBE = 4'd6;
    localparam logic [3:0] D_HOLD   = 4'd7;
    localparam logic [3:0] D_WAIT   = 4'd8;
    localparam logic [3:0] R_SETUP  = 4'd9;
    localparam logic [3:0] R_STROBE = 4'd10;
    localparam logic [3:0] R_HOLD   = 4'd11;

    localparam int MAX_ST = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_SH = (MAX_ST > HOLD_CYCLES) ? MAX_ST : HOLD_CYCLES;
    localparam int MAX_AW = (MAX_SH > ADDR_WAIT_CYCLES) ? MAX_SH : ADDR_WAIT_CYCLES;
    localparam int MAX_P  = (MAX_AW > DATA_WAIT_CYCLES) ? MAX_AW : DATA_WAIT_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    // Counter is loaded with (length - 1) and the phase ends when it reads zero.
    localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_AWAIT  = CW'((ADDR_WAIT_CYCLES > 0) ? ADDR_WAIT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LD_DWAIT  = CW'((DATA_WAIT_CYCLES > 0) ? DATA_WAIT_CYCLES - 1 : 0);

    logic [3:0]            state;
    logic [3:0]            nxt_state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         nxt_load;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        nxt_state = IDLE;
        case (state)
            A_SETUP:  nxt_state = A_STROBE;
            A_STROBE: nxt_state = A_HOLD;
            A_HOLD:   nxt_state = (ADDR_WAIT_CYCLES > 0) ? A_WAIT : D_SETUP;
            A_WAIT:   nxt_state = D_SETUP;
            D_SETUP:  nxt_state = D_STROBE;
            D_STROBE: nxt_state = D_HOLD;
            D_HOLD:   nxt_state = (DATA_WAIT_CYCLES > 0) ? D_WAIT : IDLE;
            R_SETUP:  nxt_state = R_STROBE;
            R_STROBE: nxt_state = R_HOLD;
            default:  nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_load = '0;
        case (nxt_state)
            A_SETUP, D_SETUP, R_SETUP:    nxt_load = LD_SETUP;
            A_STROBE, D_STROBE, R_STROBE: nxt_load = LD_STROBE;
            A_HOLD, D_HOLD, R_HOLD:       nxt_load = LD_HOLD;
            A_WAIT:                       nxt_load = LD_AWAIT;
            D_WAIT:                       nxt_load = LD_DWAIT;
            default:                      nxt_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            state     <= IDLE;
            cnt       <= '0;
            address   <= 1'b0;
            bus_dout  <= '0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE) begin
                if (req_valid && req_ready) begin
                    state   <= req_rd ? R_SETUP : A_SETUP;
                    cnt     <= LD_SETUP;
                    address <= 1'b0;
                    // Reads leave bus_dout untouched; writes capture both bytes now.
                    if (!req_rd) begin
                        bus_dout <= req_addr;
                        data_q   <= req_data;
                    end
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                state <= nxt_state;
                cnt   <= nxt_load;
                if (nxt_state == D_SETUP) begin
                    address  <= 1'b1;
                    bus_dout <= data_q;
                end
                if (state == R_STROBE) begin
                    rsp_data  <= bus_din;
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

    // Strobes decode straight from state so the async reset releases them immediately.
    assign cs_n      = !(state inside {A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD,
                                       R_SETUP, R_STROBE, R_HOLD});
    assign wr_n      = !(state == A_STROBE || state == D_STROBE);
    assign rd_n      = !(state == R_STROBE);
    assign req_ready = ic_n && (state == IDLE);

endmodule

// File: tb/tb_opl2_host_bus_master.sv
// Directed bench for opl2_host_bus_master: default timing instance plus a zero-recovery instance.
module tb_opl2_host_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       ic_n, req_valid, req_valid_z, req_rd;
    logic [7:0] req_addr, req_data, bus_din;
    logic       req_ready, rsp_valid, cs_n, wr_n, rd_n, address;
    logic [7:0] rsp_data, bus_dout;
    logic       z_ready, z_rsp_valid, z_cs_n, z_wr_n, z_rd_n, z_address;
    logic [7:0] z_rsp_data, z_bus_dout;

    int total = 0;
    int bad   = 0;

    opl2_host_bus_master dut (
        .clk(clk), .ic_n(ic_n), .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .address(address), .bus_dout(bus_dout),
        .bus_din(bus_din)
    );

    opl2_host_bus_master #(.ADDR_WAIT_CYCLES(0), .DATA_WAIT_CYCLES(0)) dut_z (
        .clk(clk), .ic_n(ic_n), .req_valid(req_valid_z), .req_ready(z_ready), .req_rd(req_rd),
        .req_addr(req_addr), .req_data(req_data), .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data),
        .cs_n(z_cs_n), .wr_n(z_wr_n), .rd_n(z_rd_n), .address(z_address), .bus_dout(z_bus_dout),
        .bus_din(bus_din)
    );

    // Bus monitor and register snooper for the default instance.
    int         overlap_cnt = 0, rsp_cnt = 0, wr_low_cnt = 0, stab_err = 0;
    logic [7:0] snoop_regs [0:255];
    logic [7:0] snoop_idx = 8'h00;
    logic       prev_strobe = 1'b0, prev_a = 1'b0;
    logic [7:0] prev_d = 8'h00;

    initial for (int i = 0; i < 256; i++) snoop_regs[i] = 8'h00;

    always @(negedge clk) begin
        if (!wr_n && !rd_n) overlap_cnt++;
        if (!wr_n) wr_low_cnt++;
        if (rsp_valid) rsp_cnt++;
        if (!cs_n && !wr_n) begin
            if (address) snoop_regs[snoop_idx] = bus_dout;
            else snoop_idx = bus_dout;
        end
        if ((!wr_n || !rd_n) && prev_strobe && (address !== prev_a || bus_dout !== prev_d))
            stab_err++;
        prev_strobe = !wr_n || !rd_n;
        prev_a      = address;
        prev_d      = bus_dout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int cyc);
        @(negedge clk);
        req_rd = 1'b0; req_addr = a; req_data = d; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready && cyc < 300);
    endtask

    task automatic test_reset();
        ic_n = 1'b0; req_valid = 1'b0; req_valid_z = 1'b0; req_rd = 1'b0;
        req_addr = 8'h00; req_data = 8'h00; bus_din = 8'h00;
        #12;
        total++;
        if ({cs_n, wr_n, rd_n, address, rsp_valid, req_ready} !== 6'b111000 ||
            bus_dout !== 8'h00 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b dout=%h rsp=%h want=111000 dout=00 rsp=00",
                     {cs_n, wr_n, rd_n, address, rsp_valid, req_ready}, bus_dout, rsp_data);
        end
        @(negedge clk);
        ic_n = 1'b1;
        @(negedge clk);
        total++;
        if ({cs_n, wr_n, rd_n, address, req_ready} !== 5'b11101 || bus_dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_release got=%b dout=%h want=11101 dout=00",
                     {cs_n, wr_n, rd_n, address, req_ready}, bus_dout);
        end
        total++;
        if (z_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_z got=%b want=1", z_ready);
        end
    endtask

    task automatic test_write();
        int errs = 0, first = -1, w0;
        logic e_cs, e_wr, e_a0, e_rdy;
        logic [7:0] e_d;
        w0 = wr_low_cnt;
        @(negedge clk);
        req_rd = 1'b0; req_addr = 8'h02; req_data = 8'hFF; req_valid = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_ready_before got=%b want=1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = 8'hAA; req_data = 8'h55;
        for (int k = 0; k <= 104; k++) begin
            @(negedge clk);
            e_cs  = !((k <= 3) || (k >= 16 && k <= 19));
            e_wr  = !(k == 1 || k == 2 || k == 17 || k == 18);
            e_a0  = (k >= 16);
            e_d   = (k >= 16) ? 8'hFF : 8'h02;
            e_rdy = (k == 104);
            if (cs_n !== e_cs || wr_n !== e_wr || rd_n !== 1'b1 || req_ready !== e_rdy ||
                (!cs_n && (address !== e_a0 || bus_dout !== e_d))) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL write_sequence got=%0d bad cycles (first after edge %0d) want=0",
                     errs, first);
        end
        total++;
        if (wr_low_cnt - w0 !== 4) begin
            bad++;
            $display("FAIL write_strobe_cycles got=%0d want=4", wr_low_cnt - w0);
        end
        total++;
        if (snoop_regs[8'h02] !== 8'hFF) begin
            bad++;
            $display("FAIL write_snoop got=%h want=ff", snoop_regs[8'h02]);
        end
    endtask

    task automatic test_read();
        int errs = 0, first = -1, r0, w0;
        logic e_cs, e_rd, e_rv, e_rdy;
        r0 = rsp_cnt; w0 = wr_low_cnt;
        @(negedge clk);
        bus_din = 8'hC0; req_rd = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            e_cs  = !(k <= 3);
            e_rd  = !(k == 1 || k == 2);
            e_rv  = (k == 3);
            e_rdy = (k == 4);
            if (cs_n !== e_cs || rd_n !== e_rd || wr_n !== 1'b1 || rsp_valid !== e_rv ||
                req_ready !== e_rdy || (!cs_n && address !== 1'b0)) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        bus_din = 8'h00;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL read_sequence got=%0d bad cycles (first after edge %0d) want=0",
                     errs, first);
        end
        total++;
        if (rsp_data !== 8'hC0) begin
            bad++;
            $display("FAIL read_data got=%h want=c0", rsp_data);
        end
        total++;
        if (rsp_cnt - r0 !== 1 || wr_low_cnt - w0 !== 0) begin
            bad++;
            $display("FAIL read_pulses got rsp=%0d wr=%0d want rsp=1 wr=0",
                     rsp_cnt - r0, wr_low_cnt - w0);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, cyc = 0, r0;
        r0 = rsp_cnt;
        @(negedge clk);
        bus_din = 8'h5A; req_rd = 1'b0; req_addr = 8'h04; req_data = 8'h21; req_valid = 1'b1;
        @(posedge clk);
        #1 req_rd = 1'b1;
        while (n_acc < 60 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (req_ready) n_acc++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (n_acc !== 60) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d want=60 (timeout)", n_acc);
        end
        // Write idles after edge 104, then every read takes 4 busy cycles plus 1 idle cycle.
        total++;
        if (cyc !== 400) begin
            bad++;
            $display("FAIL b2b_last_accept_cycle got=%0d want=400", cyc);
        end
        total++;
        if (rsp_cnt - r0 !== 60) begin
            bad++;
            $display("FAIL b2b_responses got=%0d want=60", rsp_cnt - r0);
        end
        total++;
        if (overlap_cnt !== 0 || stab_err !== 0) begin
            bad++;
            $display("FAIL b2b_bus_rules got overlap=%0d unstable=%0d want 0 0",
                     overlap_cnt, stab_err);
        end
        total++;
        if (snoop_regs[8'h04] !== 8'h21 || rsp_data !== 8'h5A) begin
            bad++;
            $display("FAIL b2b_data got reg04=%h rsp=%h want 21 5a", snoop_regs[8'h04], rsp_data);
        end
        bus_din = 8'h00;
    endtask

    task automatic test_reset_abort();
        int r0, cyc;
        r0 = rsp_cnt;
        @(negedge clk);
        req_rd = 1'b0; req_addr = 8'h10; req_data = 8'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (18) @(negedge clk);
        total++;
        if (wr_n !== 1'b0 || address !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_dstrobe got wr_n=%b a0=%b want 0 1", wr_n, address);
        end
        #1 ic_n = 1'b0;
        #1;
        total++;
        if ({cs_n, wr_n, rd_n, req_ready, address} !== 5'b11100 || bus_dout !== 8'h00) begin
            bad++;
            $display("FAIL abort_async_release got=%b dout=%h want=11100 dout=00",
                     {cs_n, wr_n, rd_n, req_ready, address}, bus_dout);
        end
        #1 ic_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || cs_n !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle got ready=%b cs_n=%b want 1 1", req_ready, cs_n);
        end
        repeat (5) @(negedge clk);
        total++;
        if (rsp_cnt !== r0) begin
            bad++;
            $display("FAIL abort_no_response got=%0d want=%0d", rsp_cnt, r0);
        end
        do_write(8'h06, 8'h55, cyc);
        total++;
        if (cyc !== 105 || snoop_regs[8'h06] !== 8'h55) begin
            bad++;
            $display("FAIL abort_next_write got cyc=%0d reg06=%h want 105 55",
                     cyc, snoop_regs[8'h06]);
        end
    endtask

    task automatic test_zero_wait();
        int errs = 0, first = -1;
        logic e_cs, e_wr, e_a0, e_rdy;
        logic [7:0] e_d;
        @(negedge clk);
        req_rd = 1'b0; req_addr = 8'h08; req_data = 8'h3C; req_valid_z = 1'b1;
        @(posedge clk);
        #1 req_valid_z = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            e_cs  = (k == 8);
            e_wr  = !(k == 1 || k == 2 || k == 5 || k == 6);
            e_a0  = (k >= 4);
            e_d   = (k >= 4) ? 8'h3C : 8'h08;
            e_rdy = (k == 8);
            if (z_cs_n !== e_cs || z_wr_n !== e_wr || z_rd_n !== 1'b1 || z_ready !== e_rdy ||
                z_rsp_valid !== 1'b0 || (!z_cs_n && (z_address !== e_a0 || z_bus_dout !== e_d))) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL zero_wait_sequence got=%0d bad cycles (first after edge %0d) want=0",
                     errs, first);
        end
        total++;
        if (z_rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL zero_wait_rsp_data got=%h want=00", z_rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
